// File: rtl/led_pkg.sv
// Shared types and helpers for the LED frame sequencer.
//   seq_state_t : sequencer FSM states
//   PIX_W       : pixel word width (24-bit RGB / GRB)
//   rgb_to_grb  : reorders a buffer pixel {R,G,B} into the strip's {G,R,B}
//   scale8      : per-channel brightness scale, used when LED_BRIGHTNESS_EN is defined
package led_pkg;

  localparam int PIX_W = 24;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_RD,
    S_LOAD,
    S_SEND,
    S_LATCH,
    S_DONE
  } seq_state_t;

  function automatic logic [PIX_W-1:0] rgb_to_grb(input logic [PIX_W-1:0] rgb);
    return {rgb[15:8], rgb[23:16], rgb[7:0]};
  endfunction

  // (c * (b + 1)) >> 8 on a 16-bit product: b=255 passes c through, b=0 gives 0.
  function automatic logic [7:0] scale8(input logic [7:0] c, input logic [7:0] b);
    logic [15:0] p;
    p = {8'd0, c} * ({8'd0, b} + 16'd1);
    return p[15:8];
  endfunction

endpackage

// File: rtl/led_latch_timer.sv
// Latch-gap timer for the frame sequencer.
//   clk, rst : clock, async active-high reset
//   en       : high for the whole LATCH state
//   expired  : high in the RESET_CYCLES-th consecutive cycle of en
// The counter is preloaded while idle so the gap is exact from the first
// enabled cycle; RESET_CYCLES must be >= 1.
module led_latch_timer #(
  parameter int RESET_CYCLES = 2880
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic expired
);

  localparam int CW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [CW-1:0] INIT = CW'(RESET_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              cnt <= INIT;
    else if (!en)         cnt <= INIT;
    else if (cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign expired = en && (cnt == '0);

endmodule

// File: rtl/led_frame_sequencer.sv
// Sequences one frame of pixels from the pixel buffer into a WS2812 bit-serial
// driver, then holds the line idle for the latch gap.
// Ports:
//   clk, rst    : clock, async active-high reset
//   start       : 1-cycle frame request, taken only in IDLE
//   busy        : high from the cycle after start is taken through DONE
//   frame_done  : 1-cycle pulse at the end of the latch gap
//   pix_addr    : pixel buffer read address (buffer has 1-cycle read latency)
//   pix_data    : {R,G,B} from the buffer
//   drv_rgb     : {G,R,B} word for the driver, held from drv_load until drv_done
//   drv_load    : 1-cycle load strobe to the driver
//   drv_done    : driver finished the current word (only observed in SEND)
//   brightness  : global scale, present only with LED_BRIGHTNESS_EN defined
// Build option: LED_BRIGHTNESS_EN adds the brightness port and per-channel scaling.
module led_frame_sequencer
  import led_pkg::*;
#(
  parameter int NUM_LEDS     = 60,
  parameter int RESET_CYCLES = 2880,
  parameter int AW           = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             frame_done,
  output logic [AW-1:0]    pix_addr,
  input  logic [PIX_W-1:0] pix_data,
  output logic [PIX_W-1:0] drv_rgb,
  output logic             drv_load,
  input  logic             drv_done
`ifdef LED_BRIGHTNESS_EN
  ,
  input  logic [7:0]       brightness
`endif
);

  localparam logic [AW-1:0] LAST = AW'(NUM_LEDS - 1);

  seq_state_t      state, state_nxt;
  logic [AW-1:0]   idx;
  logic            latch_expired;
  logic [PIX_W-1:0] pix_scaled;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = S_FETCH;
      S_FETCH:   state_nxt = S_WAIT_RD;
      S_WAIT_RD: state_nxt = S_LOAD;
      S_LOAD:    state_nxt = S_SEND;
      S_SEND:    if (drv_done) state_nxt = (idx == LAST) ? S_LATCH : S_FETCH;
      S_LATCH:   if (latch_expired) state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy       = (state != S_IDLE);
    drv_load   = (state == S_LOAD);
    frame_done = (state == S_DONE);
  end

  // The address register changes on entry to FETCH, so the buffer word is
  // valid during WAIT_RD and is captured at the end of it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx     <= '0;
      drv_rgb <= '0;
    end else begin
      if (state == S_IDLE && start)
        idx <= '0;
      else if (state == S_SEND && drv_done && idx != LAST)
        idx <= idx + 1'b1;
      if (state == S_WAIT_RD)
        drv_rgb <= rgb_to_grb(pix_scaled);
    end
  end

  assign pix_addr = idx;

`ifdef LED_BRIGHTNESS_EN
  always_comb begin
    pix_scaled = {scale8(pix_data[23:16], brightness),
                  scale8(pix_data[15:8],  brightness),
                  scale8(pix_data[7:0],   brightness)};
  end
`else
  always_comb begin
    pix_scaled = pix_data;
  end
`endif

  led_latch_timer #(
    .RESET_CYCLES(RESET_CYCLES)
  ) u_latch (
    .clk    (clk),
    .rst    (rst),
    .en     (state == S_LATCH),
    .expired(latch_expired)
  );

endmodule

// File: tb/tb_led_frame_sequencer.sv
// Directed bench for led_frame_sequencer: a 3-LED instance (frame order,
// timing, ignored start, mid-frame reset) and a 1-LED instance (single pixel,
// latch gap, optional brightness scaling with LED_BRIGHTNESS_EN).
module tb_led_frame_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int vec  = 0;
  int miss = 0;
  int cyc  = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] bright = 8'd255;

  // ---------------- instance A: 3 LEDs ----------------
  logic        a_start = 1'b0;
  logic        a_busy, a_fd, a_load, a_done;
  logic [1:0]  a_addr;
  logic [23:0] a_pix = '0;
  logic [23:0] a_rgb;
  logic [23:0] a_mem [0:2];
  int          a_cnt = 0;
  int          a_fd_n = 0;
  int          a_fd_cyc = 0;
  logic [23:0] a_rgb_q [$];
  int          a_addr_q [$];
  int          a_load_cyc [$];
  int          a_done_cyc [$];

  led_frame_sequencer #(.NUM_LEDS(3), .RESET_CYCLES(20)) u_dut_a (
    .clk(clk), .rst(rst), .start(a_start), .busy(a_busy), .frame_done(a_fd),
    .pix_addr(a_addr), .pix_data(a_pix), .drv_rgb(a_rgb), .drv_load(a_load),
    .drv_done(a_done)
`ifdef LED_BRIGHTNESS_EN
    , .brightness(bright)
`endif
  );

  // Buffer with 1-cycle read latency; driver model answers 10 cycles after load.
  assign a_done = (a_cnt == 1);
  always @(posedge clk) begin
    a_pix <= a_mem[a_addr];
    if (rst)              a_cnt <= 0;
    else if (a_load)      a_cnt <= 10;
    else if (a_cnt != 0)  a_cnt <= a_cnt - 1;
    if (a_load) begin
      a_rgb_q.push_back(a_rgb);
      a_addr_q.push_back(int'(a_addr));
      a_load_cyc.push_back(cyc);
    end
    if (a_done) a_done_cyc.push_back(cyc);
    if (a_fd) begin
      a_fd_n   <= a_fd_n + 1;
      a_fd_cyc <= cyc;
    end
  end

  // ---------------- instance B: 1 LED ----------------
  logic        b_start = 1'b0;
  logic        b_busy, b_fd, b_load, b_done;
  logic [0:0]  b_addr;
  logic [23:0] b_pix = '0;
  logic [23:0] b_rgb;
  int          b_cnt = 0;
  int          b_fd_n = 0;
  int          b_fd_cyc = 0;
  int          b_done_cyc = 0;
  logic        b_addr_nz = 1'b0;
  logic [23:0] b_rgb_q [$];
  int          b_addr_q [$];

  led_frame_sequencer #(.NUM_LEDS(1), .RESET_CYCLES(20)) u_dut_b (
    .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .frame_done(b_fd),
    .pix_addr(b_addr), .pix_data(b_pix), .drv_rgb(b_rgb), .drv_load(b_load),
    .drv_done(b_done)
`ifdef LED_BRIGHTNESS_EN
    , .brightness(bright)
`endif
  );

  assign b_done = (b_cnt == 1);
  always @(posedge clk) begin
    b_pix <= 24'hFF8001;
    if (rst)              b_cnt <= 0;
    else if (b_load)      b_cnt <= 10;
    else if (b_cnt != 0)  b_cnt <= b_cnt - 1;
    if (b_addr != 1'b0) b_addr_nz <= 1'b1;
    if (b_load) begin
      b_rgb_q.push_back(b_rgb);
      b_addr_q.push_back(int'(b_addr));
    end
    if (b_done) b_done_cyc <= cyc;
    if (b_fd) begin
      b_fd_n   <= b_fd_n + 1;
      b_fd_cyc <= cyc;
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_fd(input string tag, input bit sel_b, input int target);
    int n;
    n = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      n = sel_b ? b_fd_n : a_fd_n;
      if (n >= target) return;
    end
    chk({tag, "_timeout"}, n, target);
  endtask

  task automatic wait_a_loads(input string tag, input int target);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (a_rgb_q.size() >= target) return;
    end
    chk({tag, "_timeout"}, a_rgb_q.size(), target);
  endtask

  int fd0, nl;

  initial begin
    a_mem[0] = 24'hFF0000;
    a_mem[1] = 24'h00FF00;
    a_mem[2] = 24'h0000FF;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",   a_busy, 0);
    chk("rst_load",   a_load, 0);
    chk("rst_fd",     a_fd,   0);
    chk("rst_addr",   a_addr, 0);
    chk("rst_rgb",    a_rgb,  0);
    chk("rst_b_busy", b_busy, 0);
    rst = 1'b0;

    // Frame on A; start latency, then a second start mid-frame
    @(negedge clk);
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    chk("busy_n1", a_busy, 1);
    chk("load_n1", a_load, 0);
    @(posedge clk); #1;
    chk("load_n2", a_load, 0);
    @(posedge clk); #1;
    chk("load_n3", a_load, 1);
    repeat (5) @(negedge clk);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    wait_fd("frame1", 1'b0, 1);
    repeat (30) @(negedge clk);
    chk("f1_fd_cnt", a_fd_n, 1);
    chk("f1_loads",  a_rgb_q.size(), 3);
    chk("f1_busy",   a_busy, 0);
    if (a_rgb_q.size() == 3 && a_done_cyc.size() == 3) begin
      chk("f1_rgb0", a_rgb_q[0], 24'h00FF00);
      chk("f1_rgb1", a_rgb_q[1], 24'hFF0000);
      chk("f1_rgb2", a_rgb_q[2], 24'h0000FF);
      chk("f1_addr0", a_addr_q[0], 0);
      chk("f1_addr1", a_addr_q[1], 1);
      chk("f1_addr2", a_addr_q[2], 2);
      chk("f1_gap",   a_load_cyc[1] - a_done_cyc[0], 3);
      chk("f1_gap2",  a_load_cyc[2] - a_done_cyc[1], 3);
      chk("f1_latch", a_fd_cyc - a_done_cyc[2], 21);
    end

    // Reset while LED 1 is in SEND, then restart
    fd0 = a_fd_n;
    nl  = a_rgb_q.size();
    @(negedge clk);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    wait_a_loads("mid_led1", nl + 2);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mr_load", a_load, 0);
    chk("mr_busy", a_busy, 0);
    chk("mr_addr", a_addr, 0);
    chk("mr_rgb",  a_rgb,  0);
    chk("mr_fd",   a_fd,   0);
    @(negedge clk);
    rst = 1'b0;
    chk("mr_no_fd", a_fd_n, fd0);
    nl = a_rgb_q.size();
    @(negedge clk);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    wait_fd("frame2", 1'b0, fd0 + 1);
    repeat (5) @(negedge clk);
    chk("f2_loads", a_rgb_q.size() - nl, 3);
    if (a_rgb_q.size() > nl) begin
      chk("f2_addr0", a_addr_q[nl], 0);
      chk("f2_rgb0",  a_rgb_q[nl], 24'h00FF00);
    end

    // Single-LED instance
    @(negedge clk);
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    wait_fd("frame_b", 1'b1, 1);
    repeat (10) @(negedge clk);
    chk("b_fd_cnt", b_fd_n, 1);
    chk("b_loads",  b_rgb_q.size(), 1);
    chk("b_addr_nz", b_addr_nz, 0);
    chk("b_latch",  b_fd_cyc - b_done_cyc, 21);
    if (b_rgb_q.size() == 1) begin
      chk("b_addr0", b_addr_q[0], 0);
      chk("b_rgb0",  b_rgb_q[0], 24'h80FF01);
    end

`ifdef LED_BRIGHTNESS_EN
    bright = 8'd127;
    @(negedge clk);
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    wait_fd("frame_b127", 1'b1, 2);
    repeat (5) @(negedge clk);
    chk("b127_loads", b_rgb_q.size(), 2);
    if (b_rgb_q.size() == 2) chk("b127_rgb", b_rgb_q[1], 24'h407F00);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
